frame_streamer: RTL and testbench
=================================

FRAME_STREAMER -- requirements
Module: frame_streamer

Interface
REQ-001 SHALL have parameter MAPSIZE, default 32: frame width and height in pixels (frame = MAPSIZE*MAPSIZE pixels, raster order).
REQ-002 SHALL have parameter GAP, default 0: idle cycles inserted between consecutive valid output pixels (0..15).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port wr_en  input  1  frame-buffer write strobe.
REQ-006 SHALL have port wr_addr  input  $clog2(MAPSIZE*MAPSIZE)  frame-buffer write address.
REQ-007 SHALL have port wr_data  input  8 signed  pixel to store.
REQ-008 SHALL have port go  input  1  request to stream the stored frame.
REQ-009 SHALL have port abort  input  1  terminate an in-progress frame.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port start_out  output  1  one-cycle pulse to the downstream layer's start input.
REQ-012 SHALL have port data_valid_out  output  1  pixel_out is valid this cycle.
REQ-013 SHALL have port pixel_out  output  8 signed  streamed pixel.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse after the last pixel.

Function
REQ-015 SHALL contain a MAPSIZE*MAPSIZE x 8-bit frame buffer; a write at (wr_addr, wr_data) SHALL take effect when wr_en=1 and busy=0.
REQ-016 SHALL ignore wr_en while busy=1 (buffer contents unchanged).
REQ-017 SHALL implement states IDLE, START, STREAM, GAPWAIT, DONE.
REQ-018 IDLE: go=1 -> START; otherwise stay.
REQ-019 START: start_out=1 for exactly this cycle; read pointer cleared to 0; next state STREAM.
REQ-020 STREAM: data_valid_out=1 and pixel_out=buffer[ptr]; ptr increments; after the pixel at ptr=MAPSIZE*MAPSIZE-1 -> DONE; else -> GAPWAIT if GAP>0, else remain in STREAM.
REQ-021 GAPWAIT: data_valid_out=0 for exactly GAP cycles, then -> STREAM.
REQ-022 DONE: frame_done=1 for this cycle only; next state IDLE.
REQ-023 Latency: go sampled high at edge N -> start_out high in cycle N+1 -> first valid pixel (buffer[0]) in cycle N+2.
REQ-024 With GAP=0 SHALL emit MAPSIZE*MAPSIZE valid pixels on consecutive cycles with no bubble.
REQ-025 pixel_out SHALL be 0 whenever data_valid_out=0.
REQ-026 All outputs SHALL be registered (no combinational path from inputs to outputs).
REQ-027 go while busy=1 SHALL be ignored (not queued).
REQ-028 abort=1 in START, STREAM or GAPWAIT SHALL force IDLE on the next edge with data_valid_out=0, no frame_done; abort in IDLE or DONE SHALL have no effect.
REQ-029 abort and go both high in IDLE: go wins (new frame starts).
REQ-030 A go arriving the cycle after frame_done (back in IDLE) SHALL start a new frame with identical timing.
REQ-031 Buffer read addressing SHALL not wrap mid-frame; ptr SHALL never exceed MAPSIZE*MAPSIZE-1.

Reset
REQ-032 rst_n=0 SHALL asynchronously force state IDLE, ptr=0, busy=0, start_out=0, data_valid_out=0, pixel_out=0, frame_done=0.
REQ-033 Reset SHALL NOT clear frame-buffer contents.
REQ-034 rst_n asserted mid-frame SHALL drop data_valid_out immediately and produce no frame_done; after release, go restarts from pixel 0.

Verification
REQ-035 Load buffer[i]=i mod 128 (MAPSIZE=32, GAP=0), pulse go -> start_out one cycle later, then 1024 consecutive valid pixels 0,1,..,127,0,..; frame_done the cycle after pixel 1023; busy low afterwards.
REQ-036 GAP=3, buffer[0..2]=-5,7,-128 -> valid pattern 1,0,0,0,1,0,0,0,1 with pixels -5,7,-128; pixel_out=0 on gap cycles.
REQ-037 Pulse go and write buffer[0]=99 during pixel 10 of a frame -> go ignored, write ignored; next frame's pixel 0 equals prior value.
REQ-038 Assert abort at pixel 500 -> data_valid_out=0 next cycle, no frame_done; following go streams from buffer[0].
REQ-039 Assert rst_n=0 asynchronously mid-frame -> all outputs 0 before next clock edge; after release, go streams unchanged buffer contents.
REQ-040 Back-to-back: go the cycle after frame_done -> second frame identical to first, start_out timing per REQ-023.

Source files
------------

// File: rtl/frame_streamer.sv
// Frame streamer: buffers one MAPSIZE x MAPSIZE frame of signed 8-bit pixels and replays it in
// raster order on request, optionally inserting GAP idle cycles between valid pixels.
module frame_streamer #(
    parameter int unsigned MAPSIZE = 32,
    parameter int unsigned GAP     = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               wr_en,
    input  logic [$clog2(MAPSIZE*MAPSIZE)-1:0] wr_addr,
    input  logic signed [7:0]                  wr_data,
    input  logic                               go,
    input  logic                               abort,
    output logic                               busy,
    output logic                               start_out,
    output logic                               data_valid_out,
    output logic signed [7:0]                  pixel_out,
    output logic                               frame_done
);

    localparam int unsigned NPIX = MAPSIZE * MAPSIZE;
    localparam int unsigned AW   = $clog2(NPIX);
    localparam logic [AW-1:0] LastPix = AW'(NPIX - 1);
    localparam logic [3:0]    GapLoad = 4'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [2:0] {StIdle, StStart, StStream, StGapWait, StDone} state_e;

    logic signed [7:0] mem_q [NPIX];
    state_e            state_q;
    logic [AW-1:0]     ptr_q;
    logic [AW-1:0]     ptr_inc;
    logic [3:0]        gap_q;
    logic              busy_q;
    logic              start_q;
    logic              valid_q;
    logic              done_q;
    logic signed [7:0] pixel_q;

    assign ptr_inc = ptr_q + AW'(1);

    // Frame buffer has no reset so its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_en && !busy_q) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            gap_q   <= '0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            valid_q <= 1'b0;
            pixel_q <= '0;
            done_q  <= 1'b0;
        end else begin
            start_q <= 1'b0;
            valid_q <= 1'b0;
            pixel_q <= '0;
            done_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (go) begin
                        state_q <= StStart;
                        busy_q  <= 1'b1;
                        start_q <= 1'b1;
                        ptr_q   <= '0;
                    end
                end
                StStart: begin
                    if (abort) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= StStream;
                        valid_q <= 1'b1;
                        pixel_q <= mem_q[ptr_q];
                    end
                end
                StStream: begin
                    if (abort) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else if (ptr_q == LastPix) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else if (GAP > 0) begin
                        ptr_q   <= ptr_inc;
                        state_q <= StGapWait;
                        gap_q   <= GapLoad;
                    end else begin
                        ptr_q   <= ptr_inc;
                        valid_q <= 1'b1;
                        pixel_q <= mem_q[ptr_inc];
                    end
                end
                StGapWait: begin
                    if (abort) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else if (gap_q == 4'd0) begin
                        state_q <= StStream;
                        valid_q <= 1'b1;
                        pixel_q <= mem_q[ptr_q];
                    end else begin
                        gap_q <= gap_q - 4'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy           = busy_q;
    assign start_out      = start_q;
    assign data_valid_out = valid_q;
    assign pixel_out      = pixel_q;
    assign frame_done     = done_q;

endmodule

// File: tb/tb_frame_streamer.sv
// Bench for frame_streamer: two instances (GAP=0 and GAP=3) share all inputs and are compared
// every cycle against a frame model derived from the buffer contents and cycle arithmetic.
module tb_frame_streamer;

    localparam int MS    = 32;
    localparam int NPIX  = MS * MS;
    localparam int AW    = $clog2(NPIX);
    localparam int GAP_A = 0;
    localparam int GAP_B = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic signed [7:0] wr_data;
    logic              go;
    logic              abort;
    logic              busy_a, start_a, valid_a, done_a;
    logic signed [7:0] pix_a;
    logic              busy_b, start_b, valid_b, done_b;
    logic signed [7:0] pix_b;

    int                n_checks = 0;
    int                n_fail   = 0;
    logic signed [7:0] ref_mem [NPIX];
    bit                go_armed = 1'b0;

    always #5 clk = ~clk;

    frame_streamer #(.MAPSIZE(MS), .GAP(GAP_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .go(go), .abort(abort), .busy(busy_a), .start_out(start_a),
        .data_valid_out(valid_a), .pixel_out(pix_a), .frame_done(done_a)
    );

    frame_streamer #(.MAPSIZE(MS), .GAP(GAP_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .go(go), .abort(abort), .busy(busy_b), .start_out(start_b),
        .data_valid_out(valid_b), .pixel_out(pix_b), .frame_done(done_b)
    );

    // Expected {busy, start, valid, done, pixel} in cycle c after go was sampled (c=1 is start).
    function automatic logic [11:0] expect_cycle(input int g, input int c, input int stop_c);
        int j;
        int last_j;
        last_j = (NPIX - 1) * (g + 1);
        if (stop_c != 0 && c > stop_c) return 12'h000;
        if (c == 1) return {4'b1100, 8'h00};
        j = c - 2;
        if (j < 0 || j > last_j + 1) return 12'h000;
        if (j == last_j + 1) return {4'b1001, 8'h00};
        if (j % (g + 1) == 0) return {4'b1010, ref_mem[j / (g + 1)]};
        return {4'b1000, 8'h00};
    endfunction

    task automatic write_pixel(input int addr, input logic signed [7:0] val);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = val;
        ref_mem[addr] = val;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic load_frame(input bit random_data);
        for (int i = 0; i < NPIX; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            wr_data = random_data ? 8'($urandom) : 8'(i % 128);
            ref_mem[i] = wr_data;
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Pulses go, then checks both instances every cycle; optional disturbances at given cycles.
    task automatic play_frame(input string tag, input int abort_c, input int go_c, input int wr_c,
                              input int rst_c, input bit chain, input bit abort_at_go);
        int          stop_c;
        int          ncyc;
        logic [11:0] exp_a, exp_b, got_a, got_b;
        stop_c = (abort_c != 0) ? abort_c : rst_c;
        ncyc   = (stop_c != 0) ? stop_c + 4 : 2 + (NPIX - 1) * (GAP_B + 1) + 2;
        if (!go_armed) begin
            @(negedge clk);
            go    = 1'b1;
            abort = abort_at_go;
        end
        go_armed = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            exp_a = expect_cycle(GAP_A, c, stop_c);
            exp_b = expect_cycle(GAP_B, c, stop_c);
            got_a = {busy_a, start_a, valid_a, done_a, pix_a};
            got_b = {busy_b, start_b, valid_b, done_b, pix_b};
            n_checks += 2;
            if (got_a !== exp_a) begin
                n_fail++;
                $display("FAIL %s gap%0d cycle %0d: busy/start/valid/done=%b pixel=%0d, expected %b pixel=%0d",
                         tag, GAP_A, c, got_a[11:8], $signed(got_a[7:0]), exp_a[11:8],
                         $signed(exp_a[7:0]));
            end
            if (got_b !== exp_b) begin
                n_fail++;
                $display("FAIL %s gap%0d cycle %0d: busy/start/valid/done=%b pixel=%0d, expected %b pixel=%0d",
                         tag, GAP_B, c, got_b[11:8], $signed(got_b[7:0]), exp_b[11:8],
                         $signed(exp_b[7:0]));
            end
            if (rst_c != 0 && c == rst_c + 1) rst_n = 1'b1;
            go      = (c == go_c) || (chain && c == ncyc);
            abort   = (c == abort_c);
            wr_en   = (c == wr_c);
            wr_addr = '0;
            wr_data = 8'sd99;
            if (c == rst_c) begin
                #2 rst_n = 1'b0;
                #1;
                got_a = {busy_a, start_a, valid_a, done_a, pix_a};
                got_b = {busy_b, start_b, valid_b, done_b, pix_b};
                n_checks += 2;
                if (got_a !== 12'h000) begin
                    n_fail++;
                    $display("FAIL %s async reset gap%0d: outputs=%h, expected 000", tag, GAP_A, got_a);
                end
                if (got_b !== 12'h000) begin
                    n_fail++;
                    $display("FAIL %s async reset gap%0d: outputs=%h, expected 000", tag, GAP_B, got_b);
                end
            end
        end
        go_armed = chain;
    endtask

    task automatic test_reset();
        logic [11:0] got;
        rst_n = 1'b0; go = 1'b1; abort = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        got = {busy_a, start_a, valid_a, done_a, pix_a};
        n_checks++;
        if (got !== 12'h000) begin
            n_fail++;
            $display("FAIL reset gap0: outputs=%h, expected 000", got);
        end
        got = {busy_b, start_b, valid_b, done_b, pix_b};
        n_checks++;
        if (got !== 12'h000) begin
            n_fail++;
            $display("FAIL reset gap3: outputs=%h, expected 000", got);
        end
        rst_n = 1'b1;
        go    = 1'b0;
        repeat (2) @(negedge clk);
        got = {busy_a, start_a, valid_a, done_a, pix_a};
        n_checks++;
        if (got !== 12'h000) begin
            n_fail++;
            $display("FAIL idle after reset: outputs=%h, expected 000", got);
        end
    endtask

    task automatic test_ramp();
        load_frame(1'b0);
        play_frame("ramp", 0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_gap();
        write_pixel(0, -8'sd5);
        write_pixel(1, 8'sd7);
        write_pixel(2, -8'sd128);
        play_frame("gap", 0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        load_frame(1'b1);
        play_frame("random", 0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_busy_ignore();
        write_pixel(0, 8'sd17);
        play_frame("busy_ignore", 0, 12, 12, 0, 1'b0, 1'b0);
        play_frame("after_busy_ignore", 0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        play_frame("abort", 502, 0, 0, 0, 1'b0, 1'b0);
        play_frame("after_abort", 0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        play_frame("reset_mid", 0, 0, 0, 300, 1'b0, 1'b0);
        play_frame("after_reset_mid", 0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_go_abort_idle();
        play_frame("go_with_abort", 0, 0, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        play_frame("b2b_first", 0, 0, 0, 0, 1'b1, 1'b0);
        play_frame("b2b_second", 0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_gap();
        test_random();
        test_busy_ignore();
        test_abort();
        test_reset_mid();
        test_go_abort_idle();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
